fir_sample_ring: RTL
====================

// Module: fir_sample_ring
// PURPOSE
//  Upstream feeder for the 8-lane FIR MAC. Stores the input sample stream in a 16384-deep circular history.
//  Serves 8 consecutive past samples per row address, newest first, with one-cycle read latency.
//  Pulses datain_ready once per accepted sample. Holds off new writes until the MAC reports completion.
// PARAMETERS
//  DATA_W  18    sample width (signed Q-format, pass-through)
//  LANES   8     samples returned per row address
//  ROWS    2048  row addresses; history depth = LANES*ROWS = 16384
//  ADDR_W  11    log2(ROWS)
// PORTS
//  clock         in   1        rising-edge clock
//  reset         in   1        asynchronous, active-low reset (0 = in reset)
//  sample_in     in   18       new input sample
//  sample_valid  in   1        sample_in valid; accepted when sample_ready=1
//  sample_ready  out  1        1 = pending slot empty and not clearing
//  addr_data     in   11       row address from MAC; 0 = newest 8 taps
//  datain        out  144      {x[n-8a],...,x[n-8a-7]}; [143:126] newest, [17:0] oldest
//  datain_ready  out  1        1-cycle pulse: new sample committed, start FIR
//  fir_done      in   1        MAC dataout_ready pulse; releases the buffer
//  overrun       out  1        sticky: a sample arrived while the slot was full; cleared only by reset
// BEHAVIOUR
//  Reset values (asynchronous):
//   - sample_ready=0, datain_ready=0, overrun=0.
//   - Write pointer wp=14'h3FFF, so the first sample lands at location 0. Pending slot empty.
//   - state=CLEAR, clear row counter=0.
//  FSM CLEAR:
//   - Writes zero to row cnt of all 8 banks each cycle.
//   - Exits to IDLE after row 2047 (2048 cycles); sample_ready=0 throughout.
//  Pending slot (1 entry):
//   - Loaded when sample_valid=1 and the slot is empty.
//   - sample_valid=1 with the slot full: sample dropped, overrun<=1.
//  FSM IDLE:
//   - Slot full -> WRITE.
//  FSM WRITE (1 cycle):
//   - loc=wp+1 (mod 16384). Bank loc[2:0], row loc[13:3] <= slot.
//   - wp<=loc; slot emptied. -> NOTIFY.
//  FSM NOTIFY (1 cycle):
//   - datain_ready=1. -> BUSY.
//  FSM BUSY:
//   - No RAM writes; the slot may still fill.
//   - fir_done=1 -> IDLE.
//   - fir_done in any other state is ignored.
//  Simultaneous fir_done and sample_valid in BUSY: both take effect (slot loads, state -> IDLE, WRITE next).
//  Read path:
//   - base=wp-8*addr_data (14-bit wrap); r=base[2:0].
//   - Bank b reads row base[13:3] if b<=r, else base[13:3]-1 (mod 2048).
//   - Bank outputs are registered. r is pipelined one cycle to align with the registered outputs.
//   - Output lane j = bank (r-j) mod 8.
//   - datain is valid exactly 1 cycle after addr_data is presented.
//  Wrap-around: sample 16385 overwrites location 0. Taps beyond the history always read zero (CLEAR) until overwritten.
//  Reset mid-operation: everything returns to reset values and CLEAR reruns. An in-flight MAC run sees zeros.
// STRUCTURE
//  fir_pkg:
//   - DATA_W, LANES, ROWS, ADDR_W, HIST_W=14.
//   - State encoding: CLEAR, IDLE, WRITE, NOTIFY, BUSY.
//  Sub-module fir_sample_bank:
//   - 2048x18 simple dual-port RAM, synchronous read, one write port.
//   - Instantiated 8x.
//   - Top holds the FSM, pointer math and the output rotator.
// TESTING
//  1 Reset, wait 2048 cycles -> sample_ready rises. Every addr 0..2047 returns datain=0.
//  2 One sample 18'h10000 -> datain_ready pulse 2 cycles after acceptance. addr0: datain[143:126]=18'h10000, other lanes 0.
//  3 Samples 1..10, each released by fir_done -> addr0 = {10,9,8,7,6,5,4,3}, addr1 = {2,1,0,0,0,0,0,0}.
//  4 Write 16389 samples (value = index+1) -> addr0 lane0=16389, lane7=16382. addr2047 lane7=6; samples 1..5 are gone.
//  5 Two samples in BUSY, no fir_done -> first held, second dropped, overrun=1. fir_done -> held sample written, datain_ready pulses.
//  6 reset=0 during BUSY -> datain_ready=0 and sample_ready=0 immediately. After release, CLEAR again; addr0 reads 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared sizing, FSM encoding and bank port bundle for the FIR sample history ring.
// The history is LANES interleaved banks so one row address yields LANES consecutive taps.
package fir_pkg;
   localparam int DATA_W = 18;
   localparam int LANES  = 8;
   localparam int ROWS   = 2048;
   localparam int ADDR_W = 11;
   localparam int HIST_W = 14;
   localparam int LANE_W = 3;

   localparam logic [2:0] ST_CLEAR  = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_NOTIFY = 3'd3;
   localparam logic [2:0] ST_BUSY   = 3'd4;

   typedef logic [HIST_W-1:0] hist_ptr_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] raddr;
   } bank_req_t;

   // Banks above the base lane hold taps that belong to the previous row.
   function automatic logic [ADDR_W-1:0] bank_rd_row(input hist_ptr_t base,
                                                     input logic [LANE_W-1:0] b);
      return (b <= base[LANE_W-1:0]) ? base[HIST_W-1:LANE_W]
                                     : base[HIST_W-1:LANE_W] - ADDR_W'(1);
   endfunction
endpackage

// File: rtl/fir_sample_bank.sv
// One interleaved history bank: simple dual-port RAM, one write port,
// registered synchronous read.
module fir_sample_bank
   import fir_pkg::*;
(
   input  logic              clock,
   input  bank_req_t         req,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [ROWS];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb rdata_d = mem[req.raddr];

   always_ff @(posedge clock) begin
      if (req.we) mem[req.waddr] <= req.wdata;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/fir_sample_ring.sv
// Circular 16384-sample history feeding the 8-lane FIR MAC: one pending input slot,
// a write/notify/busy handshake with the MAC, and a rotated 8-tap read port.
module fir_sample_ring
   import fir_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       sample_in,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   input  logic [ADDR_W-1:0]       addr_data,
   output logic [LANES*DATA_W-1:0] datain,
   output logic                    datain_ready,
   input  logic                    fir_done,
   output logic                    overrun
);
   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   hist_ptr_t         wp_q, wp_d;
   logic              slot_full_q, slot_full_d;
   logic [DATA_W-1:0] slot_data_q, slot_data_d;
   logic              overrun_q, overrun_d;
   logic [LANE_W-1:0] r_q, r_d;
   logic              rd_zero_q, rd_zero_d;

   hist_ptr_t                      loc, base;
   logic [LANES-1:0][DATA_W-1:0]   rdata;

   assign loc  = wp_q + hist_ptr_t'(1);
   assign base = wp_q - {addr_data, 3'b000};

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      wp_d        = wp_q;
      slot_full_d = slot_full_q;
      slot_data_d = slot_data_q;
      overrun_d   = overrun_q;

      if (sample_valid) begin
         if (slot_full_q) begin
            overrun_d = 1'b1;
         end else if (state_q != ST_CLEAR) begin
            slot_full_d = 1'b1;
            slot_data_d = sample_in;
         end
      end

      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(ROWS - 1)) state_d = ST_IDLE;
         end
         ST_IDLE:   if (slot_full_q) state_d = ST_WRITE;
         ST_WRITE: begin
            wp_d        = loc;
            slot_full_d = 1'b0;
            state_d     = ST_NOTIFY;
         end
         ST_NOTIFY: state_d = ST_BUSY;
         ST_BUSY:   if (fir_done) state_d = ST_IDLE;
         default:   state_d = ST_CLEAR;
      endcase
   end

   // Reads issued while clearing return zero so a MAC run cut by reset sees no stale taps.
   assign r_d       = base[LANE_W-1:0];
   assign rd_zero_d = (state_q == ST_CLEAR);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= '0;
         wp_q        <= '1;
         slot_full_q <= 1'b0;
         slot_data_q <= '0;
         overrun_q   <= 1'b0;
         r_q         <= '0;
         rd_zero_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         wp_q        <= wp_d;
         slot_full_q <= slot_full_d;
         slot_data_q <= slot_data_d;
         overrun_q   <= overrun_d;
         r_q         <= r_d;
         rd_zero_q   <= rd_zero_d;
      end
   end

   for (genvar b = 0; b < LANES; b++) begin : g_bank
      bank_req_t req;
      assign req = '{
         we:    (state_q == ST_CLEAR) ||
                ((state_q == ST_WRITE) && (loc[LANE_W-1:0] == LANE_W'(b))),
         waddr: (state_q == ST_CLEAR) ? clr_cnt_q : loc[HIST_W-1:LANE_W],
         wdata: (state_q == ST_CLEAR) ? '0 : slot_data_q,
         raddr: bank_rd_row(base, LANE_W'(b))
      };
      fir_sample_bank u_bank (
         .clock (clock),
         .req   (req),
         .rdata (rdata[b])
      );
   end

   // Lane j (newest first) comes from bank r-j, wrapping within the 8 banks.
   always_comb begin
      datain = '0;
      if (!rd_zero_q) begin
         for (int j = 0; j < LANES; j++)
            datain[(LANES-1-j)*DATA_W +: DATA_W] = rdata[r_q - LANE_W'(j)];
      end
   end

   assign sample_ready = !slot_full_q && (state_q != ST_CLEAR);
   assign datain_ready = (state_q == ST_NOTIFY);
   assign overrun      = overrun_q;
endmodule
